// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: sequencer state encoding
// and the legal range of the memory read latency.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  // The memory read port is either unregistered (1) or registered (2).
  function automatic bit read_lat_ok(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// Synchronous skid FIFO holding returned read data (plus a last flag).
// The head entry is visible combinationally on rdata; depth must be a
// power of two so the pointers wrap naturally.
module stream_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_en;
  logic          full;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;
  assign rdata  = mem_q[rd_ptr_q];
  assign pop_en = pop & ~empty;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // The producer's credit scheme must never push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !pop_en));
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side sequencer: issues len consecutive reads from base (wrapping
// at MD) and streams the returned words out through a credit-controlled
// skid FIFO, so consumer backpressure never loses read data.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned MD       = 1024,
  parameter int unsigned AW       = $clog2(MD),
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned FD       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          rd,
  output logic [AW-1:0] adr_r,
  input  logic [DW-1:0] dat_r,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic          out_last
);

  localparam int unsigned   CW       = $clog2(FD) + 1;
  localparam int unsigned   OW       = $clog2(FD + READ_LAT + 2) + 1;
  localparam logic [AW-1:0] LAST_ADR = AW'(MD - 1);
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW:0]         rem_q, rem_d;
  logic                rd_q, rd_d;
  logic                rd_last_q, rd_last_d;
  logic [AW-1:0]       adr_r_q, adr_r_d;
  logic                done_q, done_d;
  logic [READ_LAT-1:0] infl_q, infl_d;
  logic [READ_LAT-1:0] infl_last_q, infl_last_d;
  logic                push, pop, fifo_empty;
  logic [DW:0]         fifo_rdata;
  logic [CW-1:0]       fifo_count;
  logic [OW-1:0]       outstanding;
  logic                credit_ok;

  // Address increment wraps by comparison so MD need not be a power of two.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a);
    return (a == LAST_ADR) ? '0 : a + 1'b1;
  endfunction

  stream_fifo #(
    .W     (DW + 1),
    .DEPTH (FD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({infl_last_q[READ_LAT-1], dat_r}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // The oldest in-flight flag marks the cycle dat_r is valid.
  assign push     = infl_q[READ_LAT-1];
  assign pop      = out_vld & out_rdy;
  assign out_vld  = ~fifo_empty;
  assign out_dat  = fifo_empty ? '0 : fifo_rdata[DW-1:0];
  assign out_last = ~fifo_empty & fifo_rdata[DW];
  assign busy     = (state_q != ST_IDLE);
  assign rd       = rd_q;
  assign adr_r    = adr_r_q;
  assign done     = done_q;

  // Words that will be owed after this edge if no new read is issued:
  // FIFO contents (less a word leaving now), reads in flight, and the read
  // currently presented to the memory. A new read fits only below FD.
  always_comb begin
    outstanding = OW'(fifo_count) + OW'(rd_q);
    for (int i = 0; i < int'(READ_LAT); i++) begin
      outstanding = outstanding + OW'(infl_q[i]);
    end
    outstanding = outstanding - OW'(pop);
    credit_ok   = (outstanding < OW'(FD));
  end

  // Shift register tracking which cycles carry returning read data.
  always_comb begin
    infl_d         = '0;
    infl_last_d    = '0;
    infl_d[0]      = rd_q;
    infl_last_d[0] = rd_last_q;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      infl_d[i]      = infl_q[i-1];
      infl_last_d[i] = infl_last_q[i-1];
    end
  end

  // Sequencer: command accept, read issue with credit check, drain.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rd_d      = 1'b0;
    rd_last_d = 1'b0;
    adr_r_d   = adr_r_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            // The FIFO is empty here, so the first read always has credit.
            rd_d      = 1'b1;
            rd_last_d = (len == LEN_ONE);
            adr_r_d   = base;
            addr_d    = next_adr(base);
            rem_d     = len - 1'b1;
            state_d   = (len == LEN_ONE) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          rd_d      = 1'b1;
          rd_last_d = (rem_q == LEN_ONE);
          adr_r_d   = addr_q;
          addr_d    = next_adr(addr_q);
          rem_d     = rem_q - 1'b1;
          if (rem_q == LEN_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, registered memory-port outputs and in-flight flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rd_q        <= 1'b0;
      rd_last_q   <= 1'b0;
      adr_r_q     <= '0;
      done_q      <= 1'b0;
      infl_q      <= '0;
      infl_last_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      rd_q        <= rd_d;
      rd_last_q   <= rd_last_d;
      adr_r_q     <= adr_r_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Configuration sanity: supported latency and enough FIFO depth to stream.
  always_ff @(posedge clk) begin
    assert (read_lat_ok(int'(READ_LAT)) && (FD >= READ_LAT + 2));
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: two instances (READ_LAT=2/MD=1024 and
// READ_LAT=1/MD=1000) each with a behavioural memory holding mem[i]=i[7:0].
// Expected addresses/data come from (base+k) mod MD for the k-th word.
module tb_ram_stream_reader;

  localparam int NI = 2;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int FD = 4;
  typedef logic [AW:0] len_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start    [NI];
  logic [AW-1:0] base     [NI];
  logic [AW:0]   len      [NI];
  logic          busy     [NI];
  logic          done     [NI];
  logic          rd       [NI];
  logic [AW-1:0] adr_r    [NI];
  logic          out_vld  [NI];
  logic          out_rdy  [NI];
  logic [DW-1:0] out_dat  [NI];
  logic          out_last [NI];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int cmd_base[NI], cmd_len[NI], rd_idx[NI], out_idx[NI];
  int rd_cnt[NI], vld_cnt[NI], done_cnt[NI], max_out[NI];
  int first_rd_cyc[NI], first_vld_cyc[NI], last_cyc[NI], done_cyc[NI], start_cyc[NI];
  logic        stall_prev[NI];
  logic [DW:0] held[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RL  = (g == 0) ? 2 : 1;
    localparam int MDG = (g == 0) ? 1024 : 1000;
    logic [DW-1:0] mem [MDG];
    logic [DW-1:0] dat_r_l;

    initial for (int i = 0; i < MDG; i++) mem[i] = DW'(i);

    if (RL == 1) begin : g_l1
      always @(posedge clk) if (rd[g]) dat_r_l <= mem[adr_r[g]];
    end else begin : g_l2
      logic [DW-1:0] s1;
      always @(posedge clk) begin
        if (rd[g]) s1 <= mem[adr_r[g]];
        dat_r_l <= s1;
      end
    end

    ram_stream_reader #(
      .DW(DW), .MD(MDG), .AW(AW), .READ_LAT(RL), .FD(FD)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .base(base[g]), .len(len[g]),
      .busy(busy[g]), .done(done[g]), .rd(rd[g]), .adr_r(adr_r[g]), .dat_r(dat_r_l),
      .out_vld(out_vld[g]), .out_rdy(out_rdy[g]), .out_dat(out_dat[g]), .out_last(out_last[g])
    );
  end

  function automatic int md_of(input int d);
    return (d == 0) ? 1024 : 1000;
  endfunction

  function automatic int rl_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the k-th read of a command targets (base+k) mod MD and
  // the k-th streamed word is that address's byte, last on k = len-1.
  task automatic monitor(input int d);
    int e;
    if (!rst_n) begin
      cmd_len[d] = 0; rd_idx[d] = 0; out_idx[d] = 0; stall_prev[d] = 1'b0;
    end else begin
      if (rd[d]) begin
        if (first_rd_cyc[d] < 0) first_rd_cyc[d] = cyc;
        chk("rd_within_len", 32'(rd_idx[d] < cmd_len[d]), 1);
        e = (cmd_base[d] + rd_idx[d]) % md_of(d);
        chk("adr_r", 32'(adr_r[d]), e);
        rd_idx[d]++;
        rd_cnt[d]++;
      end
      if (rd_idx[d] - out_idx[d] > max_out[d]) max_out[d] = rd_idx[d] - out_idx[d];
      if (stall_prev[d] && out_vld[d]) chk("stall_stable", 32'({out_last[d], out_dat[d]}), 32'(held[d]));
      stall_prev[d] = out_vld[d] && !out_rdy[d];
      held[d] = {out_last[d], out_dat[d]};
      if (out_vld[d]) begin
        vld_cnt[d]++;
        if (first_vld_cyc[d] < 0) first_vld_cyc[d] = cyc;
      end
      if (out_vld[d] && out_rdy[d]) begin
        e = (cmd_base[d] + out_idx[d]) % md_of(d);
        chk("out_dat", 32'(out_dat[d]), e & 255);
        chk("out_last", 32'(out_last[d]), 32'(out_idx[d] == cmd_len[d] - 1));
        if (out_last[d]) last_cyc[d] = cyc;
        out_idx[d]++;
      end
      if (done[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (start[d] && !busy[d]) begin
        cmd_base[d] = int'(base[d]); cmd_len[d] = int'(len[d]);
        rd_idx[d] = 0; out_idx[d] = 0; max_out[d] = 0;
        first_rd_cyc[d] = -1; first_vld_cyc[d] = -1;
        start_cyc[d] = cyc + 1;
      end
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < NI; d++) monitor(d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_busy", 32'(busy[d]), 0);
    chk("rst_done", 32'(done[d]), 0);
    chk("rst_rd", 32'(rd[d]), 0);
    chk("rst_adr_r", 32'(adr_r[d]), 0);
    chk("rst_out_vld", 32'(out_vld[d]), 0);
    chk("rst_out_last", 32'(out_last[d]), 0);
    chk("rst_out_dat", 32'(out_dat[d]), 0);
  endtask

  // mode 0: ready held high; 1: random ready; 2: ready low for 10 cycles.
  task automatic run_cmd(input int d, input int b, input int l, input int mode, input int spur_n);
    int n;
    int d0;
    base[d] = AW'(b); len[d] = len_t'(l); start[d] = 1'b1; out_rdy[d] = 1'b1;
    d0 = done_cnt[d];
    tick();
    start[d] = 1'b0;
    n = 0;
    while (done_cnt[d] == d0 && n < 500) begin
      case (mode)
        1:       out_rdy[d] = 1'($urandom_range(1, 0));
        2:       out_rdy[d] = (n < 4 || n >= 14);
        default: out_rdy[d] = 1'b1;
      endcase
      if (n == spur_n) begin
        start[d] = 1'b1; base[d] = AW'((b + 100) % md_of(d));
      end else begin
        start[d] = 1'b0;
      end
      tick();
      n++;
    end
    start[d] = 1'b0; out_rdy[d] = 1'b1;
    chk("done_seen", done_cnt[d] - d0, 1);
    chk("words_out", out_idx[d], l);
    chk("reads_issued", rd_idx[d], l);
    chk("busy_after_done", 32'(busy[d]), 0);
    chk("max_outstanding_le_fd", 32'(max_out[d] <= FD), 1);
    if (mode == 0) begin
      if (l == 0) begin
        chk("len0_done_lat", done_cyc[d] - start_cyc[d], 0);
      end else begin
        chk("first_rd_lat", first_rd_cyc[d] - start_cyc[d], 0);
        chk("first_vld_lat", first_vld_cyc[d] - start_cyc[d], rl_of(d) + 1);
        chk("last_word_cyc", last_cyc[d] - start_cyc[d], l + rl_of(d));
      end
    end
    if (l > 0) chk("done_after_last", done_cyc[d] - last_cyc[d], 1);
  endtask

  initial begin
    int r0, v0;
    rst_n = 1'b0;
    for (int d = 0; d < NI; d++) begin
      start[d] = 1'b0; base[d] = '0; len[d] = '0; out_rdy[d] = 1'b1;
      cmd_base[d] = 0; cmd_len[d] = 0; rd_idx[d] = 0; out_idx[d] = 0;
      rd_cnt[d] = 0; vld_cnt[d] = 0; done_cnt[d] = 0; max_out[d] = 0;
      first_rd_cyc[d] = -1; first_vld_cyc[d] = -1; last_cyc[d] = 0;
      done_cyc[d] = 0; start_cyc[d] = 0; stall_prev[d] = 1'b0; held[d] = '0;
    end
    tick();
    tick();
    for (int d = 0; d < NI; d++) chk_reset_outputs(d);
    rst_n = 1'b1;
    tick();

    // Basic stream, wrap at depth, backpressure, on both latencies.
    for (int d = 0; d < NI; d++) begin
      run_cmd(d, 10, 5, 0, -1);
      run_cmd(d, md_of(d) - 2, 4, 0, -1);
      run_cmd(d, 100, 16, 2, -1);
    end

    // Zero-length command: done only, no reads, no stream words.
    for (int d = 0; d < NI; d++) begin
      r0 = rd_cnt[d]; v0 = vld_cnt[d];
      run_cmd(d, 50, 0, 0, -1);
      repeat (4) tick();
      chk("len0_no_rd", rd_cnt[d] - r0, 0);
      chk("len0_no_vld", vld_cnt[d] - v0, 0);
    end

    // Start while busy with a different base must be ignored.
    for (int d = 0; d < NI; d++) run_cmd(d, 40, 8, 0, 2);

    // Randomized commands with random consumer readiness.
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < NI; d++) begin
        run_cmd(d, int'($urandom_range(md_of(d) - 1, 0)), int'($urandom_range(24, 1)), 1, -1);
      end
    end

    // Reset with three reads outstanding, then a fresh short command.
    for (int d = 0; d < NI; d++) begin
      base[d] = AW'(200); len[d] = len_t'(16); start[d] = 1'b1; out_rdy[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs(d);
      tick();
      rst_n = 1'b1;
      r0 = rd_cnt[d]; v0 = vld_cnt[d];
      repeat (6) tick();
      chk("post_rst_no_rd", rd_cnt[d] - r0, 0);
      chk("post_rst_no_vld", vld_cnt[d] - v0, 0);
      run_cmd(d, int'($urandom_range(md_of(d) - 1, 0)), 2, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
